radar_echo_emulator: RTL and testbench

RADAR_ECHO_EMULATOR -- requirements
Module: radar_echo_emulator

---
 rtl/radar_echo_emulator.sv | 136 +++++++++++++
 tb/tb_radar_echo_emulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/radar_echo_emulator.sv
// radar_echo_emulator: returns a one-cycle echo a programmable number of clk
// cycles after a transmit trigger edge, provided a target was in the beam at
// trigger time. A fixed two-cycle holdoff follows every echo or miss.
// Optional feature macro: ECHO_RETRIGGER_EN -- a trigger edge while counting
// restarts the countdown from the current echo_delay and re-latches
// target_present. Without it, trigger edges outside IDLE are discarded.
// Handshake: there is no valid/ready pair; a trigger is a 0->1 transition of
// trigger_radar_transmitter, accepted only in IDLE (and in COUNT when
// retrigger is enabled), and never queued.
module radar_echo_emulator (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger_radar_transmitter,
    input  logic [9:0] echo_delay,
    input  logic       target_present,
    output logic       echo,
    output logic       emulator_busy,
    output logic [7:0] echo_count,
    output logic [1:0] EMU_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COUNT   = 2'b01,
        ECHO    = 2'b10,
        HOLDOFF = 2'b11
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] counter;
    logic [9:0] counter_next;
    logic       tp_latched;
    logic       tp_next;
    logic       hold_cnt;
    logic       hold_next;
    logic       trig_prev;
    logic       trig_armed;
    logic       trig_edge;
    logic [9:0] load_value;

    // A trigger already high at reset release must first be seen low,
    // so edges are qualified by an arm flag that sets once trigger is 0.
    assign trig_edge  = trigger_radar_transmitter & ~trig_prev & trig_armed;

    // Zero delay is treated as one cycle.
    assign load_value = (echo_delay == 10'd0) ? 10'd1 : echo_delay;

    assign emulator_busy = (state != IDLE);
    assign EMU_state     = state;

    // Trigger history and arm flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_prev  <= 1'b0;
            trig_armed <= 1'b0;
        end else begin
            trig_prev  <= trigger_radar_transmitter;
            trig_armed <= trig_armed | ~trigger_radar_transmitter;
        end
    end

    // State register plus the datapath registers the FSM owns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            counter    <= 10'd0;
            tp_latched <= 1'b0;
            hold_cnt   <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            tp_latched <= tp_next;
            hold_cnt   <= hold_next;
        end
    end

    // Next-state logic: countdown, hit/miss decision, fixed holdoff.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        tp_next      = tp_latched;
        hold_next    = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_next   = COUNT;
                    counter_next = load_value;
                    tp_next      = target_present;
                end
            end
            COUNT: begin
`ifdef ECHO_RETRIGGER_EN
                if (trig_edge) begin
                    counter_next = load_value;
                    tp_next      = target_present;
                end else
`endif
                if (counter <= 10'd1) begin
                    counter_next = 10'd0;
                    state_next   = tp_latched ? ECHO : HOLDOFF;
                end else begin
                    counter_next = counter - 10'd1;
                end
            end
            ECHO: begin
                state_next = HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_cnt) begin
                    state_next = IDLE;
                end else begin
                    hold_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered echo pulse and saturating echo counter, both driven by
    // the transition into ECHO so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo       <= 1'b0;
            echo_count <= 8'd0;
        end else begin
            echo <= (state_next == ECHO);
            if ((state_next == ECHO) && (state != ECHO) && (echo_count != 8'hFF)) begin
                echo_count <= echo_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_radar_echo_emulator.sv
// Directed bench for radar_echo_emulator: expected echo cycles are queued
// when a trigger is driven and compared as echoes appear.
module tb_radar_echo_emulator;

    logic       clk;
    logic       rst;
    logic       trigger_radar_transmitter;
    logic [9:0] echo_delay;
    logic       target_present;
    logic       echo;
    logic       emulator_busy;
    logic [7:0] echo_count;
    logic [1:0] EMU_state;

    int          cyc;
    int          checks;
    int          errors;
    int          exp_count;
    logic [31:0] exp_q[$];

    radar_echo_emulator dut (
        .clk                       (clk),
        .rst                       (rst),
        .trigger_radar_transmitter (trigger_radar_transmitter),
        .echo_delay                (echo_delay),
        .target_present            (target_present),
        .echo                      (echo),
        .emulator_busy             (emulator_busy),
        .echo_count                (echo_count),
        .EMU_state                 (EMU_state)
    );

    // Clock and cycle counter: cyc is the index of the most recent rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every echo must match the head of the expected queue.
    always @(negedge clk) begin
        logic [31:0] exp_cyc;
        if (rst === 1'b1 && echo === 1'b1) begin
            exp_cyc = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("echo_cycle", cyc, exp_cyc);
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drive a trigger edge at the next rising edge k; hold it for 'hold' cycles.
    task automatic fire(input int d, input bit tp, input bit push, input int hold, output int k);
        @(negedge clk);
        echo_delay                = d[9:0];
        target_present            = tp;
        trigger_radar_transmitter = 1'b1;
        k = cyc + 1;
        if (push) begin
            exp_q.push_back(k + ((d == 0) ? 1 : d));
            if (exp_count < 255) exp_count++;
        end
        repeat (hold) @(negedge clk);
        trigger_radar_transmitter = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, EMU_state, 2'b00);
        check({tag, "_busy"}, emulator_busy, 1'b0);
        check({tag, "_count"}, echo_count, exp_count);
    endtask

    initial begin
        int k;
        checks    = 0;
        errors    = 0;
        exp_count = 0;
        rst                       = 1'b0;
        trigger_radar_transmitter = 1'b0;
        echo_delay                = 10'd0;
        target_present            = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_echo", echo, 1'b0);
        check_idle("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal: delay 8, target present
        fire(8, 1'b1, 1'b1, 1, k);
        check("nom_state_count", EMU_state, 2'b01);
        check("nom_busy", emulator_busy, 1'b1);
        wait_until(k + 8);
        check("nom_echo_high", echo, 1'b1);
        check("nom_count", echo_count, 8'd1);
        wait_until(k + 9);
        check("nom_holdoff", EMU_state, 2'b11);
        wait_until(k + 10);
        check("nom_busy_k10", emulator_busy, 1'b1);
        wait_until(k + 11);
        check_idle("nom_k11");

        // Inputs changing after the trigger edge do not affect the echo
        fire(8, 1'b1, 1'b1, 1, k);
        target_present = 1'b0;
        echo_delay     = 10'd3;
        wait_until(k + 11);
        check_idle("late_drop");

        // Miss: no echo, counter unchanged, IDLE after D+2
        fire(6, 1'b0, 1'b0, 1, k);
        wait_until(k + 6);
        check("miss_holdoff", EMU_state, 2'b11);
        wait_until(k + 8);
        check_idle("miss");

        // Zero delay behaves as one
        fire(0, 1'b1, 1'b1, 1, k);
        wait_until(k + 1);
        check("d0_echo", echo, 1'b1);
        wait_until(k + 4);
        check_idle("d0");

        // Maximum delay
        fire(1023, 1'b1, 1'b1, 1, k);
        wait_until(k + 1022);
        check("d1023_state", EMU_state, 2'b01);
        wait_until(k + 1026);
        check_idle("d1023");

        // Trigger held high for 30 cycles is one trigger
        fire(5, 1'b1, 1'b1, 30, k);
        wait_until(k + 40);
        check_idle("held");

        // Second trigger edge while counting
        fire(20, 1'b1, 1'b0, 1, k);
        wait_until(k + 4);
        trigger_radar_transmitter = 1'b1;
        wait_until(k + 5);
        trigger_radar_transmitter = 1'b0;
`ifdef ECHO_RETRIGGER_EN
        exp_q.push_back(k + 25);
`else
        exp_q.push_back(k + 20);
`endif
        exp_count++;
        wait_until(k + 29);
        check_idle("retrig");

        // Trigger edges in ECHO/HOLDOFF are discarded
        fire(1, 1'b1, 1'b1, 1, k);
        wait_until(k + 1);
        trigger_radar_transmitter = 1'b1;
        wait_until(k + 2);
        trigger_radar_transmitter = 1'b0;
        wait_until(k + 3);
        trigger_radar_transmitter = 1'b1;
        wait_until(k + 4);
        trigger_radar_transmitter = 1'b0;
        wait_until(k + 8);
        check_idle("holdoff_ignore");

        // Reset mid-COUNT aborts the pending echo
        fire(10, 1'b1, 1'b0, 1, k);
        wait_until(k + 4);
        rst = 1'b0;
        #1;
        exp_count = 0;
        check("rst_mid_echo", echo, 1'b0);
        check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check_idle("rst_after50");

        // Trigger high at reset release is not an edge
        rst = 1'b0;
        trigger_radar_transmitter = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_idle("trig_high_release");
        trigger_radar_transmitter = 1'b0;
        repeat (2) @(negedge clk);

        // Saturation: 300 triggers with holdoff-period edges in between
        for (int i = 0; i < 300; i++) begin
            fire(1, 1'b1, 1'b1, 1, k);
            wait_until(k + 2);
            trigger_radar_transmitter = 1'b1;
            wait_until(k + 3);
            trigger_radar_transmitter = 1'b0;
            if (i == 255) begin
                wait_until(k + 2);
                check("sat_256", echo_count, 8'd255);
            end
        end
        wait_until(cyc + 6);
        check_idle("sat_end");
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
